pipe_seg_reg: RTL and testbench
===============================

// Module: pipe_seg_reg
// PURPOSE
//  Parametrised pipeline segment register for the 5-stage MIPS pipeline (ID/EX, EX/MEM, MEM/WB).
//  Carries PC, control word and data payload between two stages.
//  Adds a valid/ready handshake with a 1-entry skid buffer, a synchronous flush (bubble insert)
//  and a replay port that injects a recovery instruction after a branch mispredict.
//  One instance per segment; stages pack their own signals into ctrl/data.
// PARAMETERS
//  PC_W          30  PC width (word address, PC[31:2])
//  CTRL_W        16  control-word width (RegDst, RegWr, ALUSrc, MemWr, ..., ALUctr)
//  DATA_W        64  data payload width (e.g. {busA,busB})
//  ZERO_ON_FLUSH  1  1: flush zeroes out_pc/out_data too; 0: only valid and ctrl cleared
//  CNT_W         16  perf counter width (SEG_PERF_CNT_EN only)
// PORTS
//  clk           in   1       clock; all state updates on rising edge
//  rst           in   1       asynchronous reset, active-high
//  in_valid      in   1       upstream beat valid
//  in_ready      out  1       accept; registered, equals !skid_valid
//  in_pc         in   PC_W    upstream PC
//  in_ctrl       in   CTRL_W  upstream control word
//  in_data       in   DATA_W  upstream payload
//  replay_valid  in   1       inject replay beat this cycle
//  replay_pc     in   PC_W    replay PC
//  replay_ctrl   in   CTRL_W  replay control word
//  replay_data   in   DATA_W  replay payload
//  flush         in   1       synchronous kill of all held and incoming beats
//  out_valid     out  1       downstream beat valid
//  out_ready     in   1       downstream accepts (0 = stall)
//  out_pc        out  PC_W    held PC
//  out_ctrl      out  CTRL_W  held control word
//  out_data      out  DATA_W  held payload
//  out_replayed  out  1       held beat came from replay port
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready=1; skid empty; counters 0. Async assert, sync-safe release.
//  accept = in_valid & in_ready; consume = out_valid & out_ready. Latency 1 cycle in->out.
//  States (out_valid, skid_valid):
//   EMPTY (0,0): accept -> ONE, out<=in.
//   ONE (1,0): accept&consume -> ONE, out<=in; accept&!consume -> FULL, skid<=in;
//              !accept&consume -> EMPTY (ctrl zeroed); neither -> hold.
//   FULL (1,1): in_ready=0; consume -> ONE, out<=skid; else hold. Skid never overwritten.
//  Priority per cycle: rst > flush > replay_valid > handshake.
//   flush: next cycle out_valid=0, skid_valid=0, out_ctrl=0, out_replayed=0, in_ready=1;
//     out_pc/out_data=0 if ZERO_ON_FLUSH else hold. Beat accepted in flush cycle is dropped.
//     replay_valid in the same cycle is ignored.
//   replay: out<=replay_*, out_valid=1, out_replayed=1, skid cleared, in_ready=1 next cycle.
//     Held and incoming beats are discarded regardless of out_ready.
//  out_replayed cleared when any non-replay beat loads out.
//  Payload is passed unmodified; no width conversion. Output regs never change while
//  out_valid & !out_ready, except on flush/replay.
//  Reset mid-operation: all state discarded immediately; no partial beat survives.
// CONFIGURATION
//  SEG_PERF_CNT_EN defined: adds outputs cnt_stall, cnt_flush, cnt_replay [CNT_W-1:0],
//   saturating at all-ones; increment on out_valid&!out_ready, flush, and replay_valid&!flush.
//   Cleared by rst only.
//  Undefined: counters and ports absent; no other behaviour change.
// TESTING
//  1 rst=1 then release, no input -> out_valid=0, out_ctrl=0, in_ready=1.
//  2 in pc=0x100, ctrl=0x00A5, data=0x1234, out_ready=1 -> next cycle out_pc=0x100, out_valid=1.
//  3 out_ready=0, beats A,B,C offered -> A held, B in skid, in_ready=0, C not accepted;
//    out_ready=1 -> out A, B, then C, in order, none lost.
//  4 FULL + flush=1 -> next cycle out_valid=0, in_ready=1, out_ctrl=0, out_data=0
//    (ZERO_ON_FLUSH=1); out_data unchanged with ZERO_ON_FLUSH=0.
//  5 replay_valid with pc=0x200 while stalled -> out_pc=0x200, out_replayed=1,
//    skid emptied; flush+replay together -> bubble only.
//  6 SEG_PERF_CNT_EN, CNT_W=4, 20 stall cycles -> cnt_stall=15 (saturated).

Source files
------------

// File: rtl/pipe_seg_if.sv
// pipe_seg_if: upstream beat, replay, flush and downstream handshake bundle for one pipeline segment.
interface pipe_seg_if #(
    parameter int PC_W   = 30,
    parameter int CTRL_W = 16,
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              replay_valid;
    logic [PC_W-1:0]   replay_pc;
    logic [CTRL_W-1:0] replay_ctrl;
    logic [DATA_W-1:0] replay_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic              out_replayed;
    modport master (
        output in_valid, in_pc, in_ctrl, in_data, replay_valid, replay_pc, replay_ctrl, replay_data,
               flush, out_ready,
        input  in_ready, out_valid, out_pc, out_ctrl, out_data, out_replayed
    );
    modport slave (
        input  in_valid, in_pc, in_ctrl, in_data, replay_valid, replay_pc, replay_ctrl, replay_data,
               flush, out_ready,
        output in_ready, out_valid, out_pc, out_ctrl, out_data, out_replayed
    );
endinterface

// File: rtl/pipe_seg_reg.sv
// pipe_seg_reg: pipeline segment register with 1-entry skid buffer, flush bubble and replay injection.
// Defining SEG_PERF_CNT_EN adds saturating stall/flush/replay counters.
module pipe_seg_reg #(
    parameter int PC_W          = 30,
    parameter int CTRL_W        = 16,
    parameter int DATA_W        = 64,
    parameter int ZERO_ON_FLUSH = 1
`ifdef SEG_PERF_CNT_EN
    , parameter int CNT_W       = 16
`endif
) (
    input logic       clk,
    input logic       rst,
    pipe_seg_if.slave seg
`ifdef SEG_PERF_CNT_EN
    , output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_flush,
    output logic [CNT_W-1:0] cnt_replay
`endif
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t            state, nxt;
    logic              accept, consume, ld_in, ld_skid, ld_out_skid, drain;
    logic [PC_W-1:0]   skid_pc;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign seg.out_valid = state != EMPTY;
    assign seg.in_ready  = state != FULL;
    assign accept        = seg.in_valid & seg.in_ready;
    assign consume       = seg.out_valid & seg.out_ready;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= EMPTY;
        else     state <= nxt;

    always_comb begin
        nxt         = state;
        ld_in       = 1'b0;
        ld_skid     = 1'b0;
        ld_out_skid = 1'b0;
        drain       = 1'b0;
        if (seg.flush) nxt = EMPTY;
        else if (seg.replay_valid) nxt = ONE;
        else case (state)
            EMPTY: begin
                nxt   = accept ? ONE : EMPTY;
                ld_in = accept;
            end
            ONE: begin
                nxt     = (accept & !consume) ? FULL : ((!accept & consume) ? EMPTY : ONE);
                ld_in   = accept & consume;
                ld_skid = accept & !consume;
                drain   = !accept & consume;
            end
            FULL: begin
                nxt         = consume ? ONE : FULL;
                ld_out_skid = consume;
            end
            default: nxt = EMPTY;
        endcase
    end

    // Output regs move only on flush, replay, a load or a drain, so a stalled beat stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg.out_pc       <= '0;
            seg.out_ctrl     <= '0;
            seg.out_data     <= '0;
            seg.out_replayed <= 1'b0;
        end else if (seg.flush) begin
            seg.out_ctrl     <= '0;
            seg.out_replayed <= 1'b0;
            if (ZERO_ON_FLUSH != 0) begin
                seg.out_pc   <= '0;
                seg.out_data <= '0;
            end
        end else if (seg.replay_valid) begin
            seg.out_pc       <= seg.replay_pc;
            seg.out_ctrl     <= seg.replay_ctrl;
            seg.out_data     <= seg.replay_data;
            seg.out_replayed <= 1'b1;
        end else if (ld_in | ld_out_skid) begin
            seg.out_pc       <= ld_in ? seg.in_pc : skid_pc;
            seg.out_ctrl     <= ld_in ? seg.in_ctrl : skid_ctrl;
            seg.out_data     <= ld_in ? seg.in_data : skid_data;
            seg.out_replayed <= 1'b0;
        end else if (drain) begin
            seg.out_ctrl     <= '0;
            seg.out_replayed <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_pc   <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (ld_skid & !seg.flush & !seg.replay_valid) begin
            skid_pc   <= seg.in_pc;
            skid_ctrl <= seg.in_ctrl;
            skid_data <= seg.in_data;
        end
    end

`ifdef SEG_PERF_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && !(&c)) ? c + 1'b1 : c;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_stall  <= '0;
            cnt_flush  <= '0;
            cnt_replay <= '0;
        end else begin
            cnt_stall  <= sat_inc(cnt_stall, seg.out_valid & !seg.out_ready);
            cnt_flush  <= sat_inc(cnt_flush, seg.flush);
            cnt_replay <= sat_inc(cnt_replay, seg.replay_valid & !seg.flush);
        end
    end
`endif
endmodule

// File: tb/tb_pipe_seg_reg.sv
// tb_pipe_seg_reg: directed table plus random traffic against a queue-based model,
// run on a ZERO_ON_FLUSH=1 and a ZERO_ON_FLUSH=0 instance driven in lockstep.
module tb_pipe_seg_reg;
    localparam int PC_W = 30, CTRL_W = 16, DATA_W = 64;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_seg_if #(.PC_W(PC_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W)) ia ();
    pipe_seg_if #(.PC_W(PC_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W)) ib ();
    assign ib.in_valid     = ia.in_valid;
    assign ib.in_pc        = ia.in_pc;
    assign ib.in_ctrl      = ia.in_ctrl;
    assign ib.in_data      = ia.in_data;
    assign ib.replay_valid = ia.replay_valid;
    assign ib.replay_pc    = ia.replay_pc;
    assign ib.replay_ctrl  = ia.replay_ctrl;
    assign ib.replay_data  = ia.replay_data;
    assign ib.flush        = ia.flush;
    assign ib.out_ready    = ia.out_ready;

`ifdef SEG_PERF_CNT_EN
    logic [3:0] cs_a, cf_a, cr_a, cs_b, cf_b, cr_b;
    pipe_seg_reg #(.PC_W(PC_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W), .ZERO_ON_FLUSH(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .seg(ia), .cnt_stall(cs_a), .cnt_flush(cf_a), .cnt_replay(cr_a));
    pipe_seg_reg #(.PC_W(PC_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W), .ZERO_ON_FLUSH(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .seg(ib), .cnt_stall(cs_b), .cnt_flush(cf_b), .cnt_replay(cr_b));
`else
    pipe_seg_reg #(.PC_W(PC_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W), .ZERO_ON_FLUSH(1)) dut_a (
        .clk(clk), .rst(rst), .seg(ia));
    pipe_seg_reg #(.PC_W(PC_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W), .ZERO_ON_FLUSH(0)) dut_b (
        .clk(clk), .rst(rst), .seg(ib));
`endif

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic              rep;
    } beat_t;

    typedef struct {
        logic              iv;
        logic [PC_W-1:0]   pc;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic              ordy;
        logic              fl;
        logic              rv;
        logic [PC_W-1:0]   rpc;
        logic              e_ov;
        logic              e_ir;
        logic [PC_W-1:0]   e_pc;
        logic [CTRL_W-1:0] e_ctrl;
        logic              e_rep;
    } vec_t;

    // Model: the segment is a FIFO of at most two beats; the head is what out_* shows.
    beat_t             q[$];
    logic [PC_W-1:0]   hold_pc[2];
    logic [DATA_W-1:0] hold_data[2];
    int m_stall, m_flush, m_replay;
    int n_cmp = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int v = 0; v < 2; v++) begin
            hold_pc[v]   = '0;
            hold_data[v] = '0;
        end
        m_stall = 0; m_flush = 0; m_replay = 0;
    endtask

    task automatic model_step();
        bit ov = q.size() > 0;
        bit ir = q.size() < 2;
        if (ov && !ia.out_ready) m_stall = m_stall < 15 ? m_stall + 1 : 15;
        if (ia.flush) m_flush = m_flush < 15 ? m_flush + 1 : 15;
        if (ia.replay_valid && !ia.flush) m_replay = m_replay < 15 ? m_replay + 1 : 15;
        if (ia.flush) begin
            q.delete();
            hold_pc[1]   = '0;
            hold_data[1] = '0;
        end else if (ia.replay_valid) begin
            q.delete();
            q.push_back('{ia.replay_pc, ia.replay_ctrl, ia.replay_data, 1'b1});
        end else begin
            if (ov && ia.out_ready) void'(q.pop_front());
            if (ia.in_valid && ir) q.push_back('{ia.in_pc, ia.in_ctrl, ia.in_data, 1'b0});
        end
        if (q.size() > 0)
            for (int v = 0; v < 2; v++) begin
                hold_pc[v]   = q[0].pc;
                hold_data[v] = q[0].data;
            end
    endtask

    task automatic chk_dut(input string tag, input int v, input logic ov, input logic ir,
                           input logic [PC_W-1:0] pc, input logic [CTRL_W-1:0] ctrl,
                           input logic [DATA_W-1:0] data, input logic rep);
        beat_t e;
        bit    ne = q.size() > 0;
        e = '{hold_pc[v], '0, hold_data[v], 1'b0};
        if (ne) e = q[0];
        chk({tag, ".out_valid"}, 64'(ov), 64'(ne));
        chk({tag, ".in_ready"}, 64'(ir), 64'(q.size() < 2));
        chk({tag, ".out_pc"}, 64'(pc), 64'(e.pc));
        chk({tag, ".out_ctrl"}, 64'(ctrl), 64'(e.ctrl));
        chk({tag, ".out_data"}, data, e.data);
        chk({tag, ".out_replayed"}, 64'(rep), 64'(e.rep));
    endtask

    task automatic check_all();
        chk_dut("a", 1, ia.out_valid, ia.in_ready, ia.out_pc, ia.out_ctrl, ia.out_data, ia.out_replayed);
        chk_dut("b", 0, ib.out_valid, ib.in_ready, ib.out_pc, ib.out_ctrl, ib.out_data, ib.out_replayed);
`ifdef SEG_PERF_CNT_EN
        chk("a.cnt_stall", 64'(cs_a), 64'(m_stall));
        chk("a.cnt_flush", 64'(cf_a), 64'(m_flush));
        chk("a.cnt_replay", 64'(cr_a), 64'(m_replay));
        chk("b.cnt_stall", 64'(cs_b), 64'(m_stall));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic apply(input vec_t t);
        ia.in_valid     = t.iv;
        ia.in_pc        = t.pc;
        ia.in_ctrl      = t.ctrl;
        ia.in_data      = t.data;
        ia.out_ready    = t.ordy;
        ia.flush        = t.fl;
        ia.replay_valid = t.rv;
        ia.replay_pc    = t.rpc;
        ia.replay_ctrl  = 16'h0077;
        ia.replay_data  = 64'(t.rpc);
    endtask

    task automatic idle();
        apply('{1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0});
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    vec_t tbl[17];

    initial begin
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset out_valid", 64'(ia.out_valid), 64'd0);
        chk("reset in_ready", 64'(ia.in_ready), 64'd1);
        chk("reset out_ctrl", 64'(ia.out_ctrl), 64'd0);
        check_all();

        //          iv  pc      ctrl     data      rdy fl rv rpc      ov ir e_pc    e_ctrl  rep
        tbl[0]  = '{1, 'h100, 'h00A5, 'h1234, 1, 0, 0, 'h000, 1, 1, 'h100, 'h00A5, 0};
        tbl[1]  = '{0, 'h000, 'h0000, 'h0000, 1, 0, 0, 'h000, 0, 1, 'h100, 'h0000, 0};
        tbl[2]  = '{1, 'h0A0, 'h0001, 'h000A, 0, 0, 0, 'h000, 1, 1, 'h0A0, 'h0001, 0};
        tbl[3]  = '{1, 'h0B0, 'h0002, 'h000B, 0, 0, 0, 'h000, 1, 0, 'h0A0, 'h0001, 0};
        tbl[4]  = '{1, 'h0C0, 'h0003, 'h000C, 0, 0, 0, 'h000, 1, 0, 'h0A0, 'h0001, 0};
        tbl[5]  = '{1, 'h0C0, 'h0003, 'h000C, 1, 0, 0, 'h000, 1, 1, 'h0B0, 'h0002, 0};
        tbl[6]  = '{1, 'h0C0, 'h0003, 'h000C, 1, 0, 0, 'h000, 1, 1, 'h0C0, 'h0003, 0};
        tbl[7]  = '{0, 'h000, 'h0000, 'h0000, 1, 0, 0, 'h000, 0, 1, 'h0C0, 'h0000, 0};
        tbl[8]  = '{1, 'h0D0, 'h0004, 'h000D, 0, 0, 0, 'h000, 1, 1, 'h0D0, 'h0004, 0};
        tbl[9]  = '{1, 'h0E0, 'h0005, 'h000E, 0, 0, 0, 'h000, 1, 0, 'h0D0, 'h0004, 0};
        tbl[10] = '{0, 'h000, 'h0000, 'h0000, 0, 0, 1, 'h200, 1, 1, 'h200, 'h0077, 1};
        tbl[11] = '{1, 'h0F0, 'h0006, 'h000F, 1, 0, 0, 'h000, 1, 1, 'h0F0, 'h0006, 0};
        tbl[12] = '{1, 'h1F0, 'h0007, 'h001F, 1, 1, 1, 'h300, 0, 1, 'h000, 'h0000, 0};
        tbl[13] = '{1, 'h0A4, 'h0008, 'h00A4, 0, 0, 0, 'h000, 1, 1, 'h0A4, 'h0008, 0};
        tbl[14] = '{1, 'h0B4, 'h0009, 'h00B4, 0, 0, 0, 'h000, 1, 0, 'h0A4, 'h0008, 0};
        tbl[15] = '{1, 'h0C4, 'h000A, 'h00C4, 0, 1, 0, 'h000, 0, 1, 'h000, 'h0000, 0};
        tbl[16] = '{0, 'h000, 'h0000, 'h0000, 1, 0, 0, 'h000, 0, 1, 'h000, 'h0000, 0};
        for (int i = 0; i < 17; i++) begin
            apply(tbl[i]);
            step();
            chk($sformatf("tbl%0d out_valid", i), 64'(ia.out_valid), 64'(tbl[i].e_ov));
            chk($sformatf("tbl%0d in_ready", i), 64'(ia.in_ready), 64'(tbl[i].e_ir));
            chk($sformatf("tbl%0d out_pc", i), 64'(ia.out_pc), 64'(tbl[i].e_pc));
            chk($sformatf("tbl%0d out_ctrl", i), 64'(ia.out_ctrl), 64'(tbl[i].e_ctrl));
            chk($sformatf("tbl%0d out_replayed", i), 64'(ia.out_replayed), 64'(tbl[i].e_rep));
        end
        chk("flush zeroes data", ia.out_data, 64'd0);
        chk("flush keeps data", ib.out_data, 64'h00A4);
        chk("flush keeps pc", 64'(ib.out_pc), 64'h00A4);

        // Twenty stalled cycles on one held beat: a 4-bit stall counter must saturate.
        do_reset();
        apply('{1'b1, 'h111, 'h0011, 'h0111, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0});
        step();
        ia.in_valid = 1'b0;
        repeat (20) step();
`ifdef SEG_PERF_CNT_EN
        chk("cnt_stall saturated", 64'(cs_a), 64'd15);
`endif
        chk("stalled beat held", 64'(ia.out_pc), 64'h111);

        // Asynchronous reset in the middle of a full segment.
        apply('{1'b1, 'h222, 'h0022, 'h0222, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0});
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("async rst out_valid", 64'(ia.out_valid), 64'd0);
        chk("async rst in_ready", 64'(ia.in_ready), 64'd1);
        chk("async rst out_pc", 64'(ia.out_pc), 64'd0);
        model_reset();
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        for (int i = 0; i < 600; i++) begin
            ia.in_valid     = $urandom_range(0, 3) != 0;
            ia.in_pc        = PC_W'($urandom);
            ia.in_ctrl      = CTRL_W'($urandom);
            ia.in_data      = {$urandom, $urandom};
            ia.out_ready    = $urandom_range(0, 2) != 0;
            ia.flush        = $urandom_range(0, 19) == 0;
            ia.replay_valid = $urandom_range(0, 14) == 0;
            ia.replay_pc    = PC_W'($urandom);
            ia.replay_ctrl  = CTRL_W'($urandom);
            ia.replay_data  = {$urandom, $urandom};
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
